// File: rtl/fan_pwm_pkg.sv
// Shared types and helpers for the fan PWM driver: FSM state encodings and
// the demand clamp that maps the signed controller output onto a duty target.
package fan_pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2
  } fan_state_e;

  // Non-positive demand means off; positive demand is floored at min_duty so a
  // running fan never stalls. The controller saturates positive values at 2^n-1.
  function automatic logic [31:0] clamp_target(input logic signed [31:0] val,
                                               input int unsigned        n,
                                               input int unsigned        min_duty);
    logic [31:0] low;
    low = $unsigned(val) & ((32'd1 << n) - 32'd1);
    if (val <= 0)
      return 32'd0;
    if (low < min_duty)
      return min_duty;
    return low;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler feeding a period counter that runs 0..2^N-2,
// so one period is 2^N-1 ticks and full-scale duty is exactly 100 %.
module pwm_timebase #(
  parameter int unsigned ADC_BITWIDTH = 8,
  parameter int unsigned PWM_PRESCALE = 50
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  output logic [ADC_BITWIDTH-1:0] cnt,
  output logic                    tick,
  output logic                    boundary
);

  localparam int unsigned N    = ADC_BITWIDTH;
  localparam int unsigned PW   = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PWM_PRESCALE - 1);
  localparam logic [N-1:0]  CMAX = {{(N-1){1'b1}}, 1'b0};

  logic [PW-1:0] pcnt;

  assign tick     = (pcnt == PMAX);
  assign boundary = tick && (cnt == CMAX);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcnt <= '0;
      cnt  <= '0;
    end else begin
      if (tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + 1'b1;

      if (boundary)
        cnt <= '0;
      else if (tick)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: clamps controller demand, kick-starts from standstill,
// slew-limits duty and changes it only at period boundaries.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OFF  | fan stopped, duty 0, waiting for enable and nonzero demand
//   ST_KICK | full duty for KICK_PERIODS periods to break stiction
//   ST_RUN  | duty tracks clamped demand, at most SLEW_STEP per period
module fan_pwm_driver
  import fan_pwm_pkg::*;
#(
  parameter int unsigned ADC_BITWIDTH = 8,
  parameter int unsigned PWM_PRESCALE = 50,
  parameter int unsigned KICK_PERIODS = 16,
  parameter int unsigned MIN_DUTY     = 32,
  parameter int unsigned SLEW_STEP    = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic signed [ADC_BITWIDTH:0] pid_val_i,
  output logic                    pwm_o,
  output logic [ADC_BITWIDTH-1:0] duty_o,
  output logic [1:0]              state_o,
  output logic                    period_strb_o
);

  localparam int unsigned N  = ADC_BITWIDTH;
  localparam int unsigned NW = N + 1;
  localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [N-1:0]  DUTY_FULL = {N{1'b1}};
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS - 1);
  localparam logic [NW-1:0] STEP      = NW'(SLEW_STEP);

  logic [N-1:0]  cnt;
  logic          tick;
  logic          boundary;
  logic [N-1:0]  cnt_next;
  logic [N-1:0]  target;
  logic          run_ok;
  logic [NW-1:0] slew;

  fan_state_e    state_q, state_d;
  logic [N-1:0]  duty_q, duty_d;
  logic [KW-1:0] kcnt_q, kcnt_d;

  pwm_timebase #(
    .ADC_BITWIDTH (ADC_BITWIDTH),
    .PWM_PRESCALE (PWM_PRESCALE)
  ) u_timebase (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .cnt      (cnt),
    .tick     (tick),
    .boundary (boundary)
  );

  assign target   = N'(clamp_target(32'(pid_val_i), N, MIN_DUTY));
  assign run_ok   = enable_i && (target != '0);
  assign cnt_next = boundary ? '0 : (tick ? cnt + 1'b1 : cnt);

  // One extra bit keeps the difference and the step sum from wrapping.
  always_comb begin
    logic [NW-1:0] t_w, d_w;
    t_w = {1'b0, target};
    d_w = {1'b0, duty_q};
    if (t_w > d_w)
      slew = ((t_w - d_w) > STEP) ? d_w + STEP : t_w;
    else
      slew = ((d_w - t_w) > STEP) ? d_w - STEP : t_w;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    kcnt_d  = kcnt_q;
    if (boundary) begin
      case (state_q)
        ST_OFF: begin
          if (run_ok) begin
            state_d = ST_KICK;
            duty_d  = DUTY_FULL;
            kcnt_d  = KICK_LAST;
          end
        end
        ST_KICK: begin
          if (!run_ok) begin
            state_d = ST_OFF;
            duty_d  = '0;
          end else if (kcnt_q == '0) begin
            state_d = ST_RUN;
            duty_d  = target;
          end else begin
            kcnt_d  = kcnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_ok) begin
            state_d = ST_OFF;
            duty_d  = '0;
          end else begin
            duty_d  = N'(slew);
          end
        end
        default: begin
          state_d = ST_OFF;
          duty_d  = '0;
        end
      endcase
    end
  end

  // pwm_o compares against next-cycle values so a new duty shows from the boundary edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_OFF;
      duty_q        <= '0;
      kcnt_q        <= '0;
      pwm_o         <= 1'b0;
      period_strb_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      kcnt_q        <= kcnt_d;
      pwm_o         <= (cnt_next < duty_d);
      period_strb_o <= boundary;
    end
  end

  assign duty_o  = duty_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver with prescale 2, N=8: one period is 510 clocks.
module tb_fan_pwm_driver;

  logic              clk = 1'b0;
  logic              rstn;
  logic              enable;
  logic signed [8:0] pid;
  logic              pwm;
  logic [7:0]        duty;
  logic [1:0]        state;
  logic              strb;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fan_pwm_driver #(
    .ADC_BITWIDTH (8),
    .PWM_PRESCALE (2),
    .KICK_PERIODS (2),
    .MIN_DUTY     (32),
    .SLEW_STEP    (4)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .enable_i      (enable),
    .pid_val_i     (pid),
    .pwm_o         (pwm),
    .duty_o        (duty),
    .state_o       (state),
    .period_strb_o (strb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strb(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!strb && cyc < 2000);
    if (cyc >= 2000)
      chk("strb_timeout", cyc, 510);
  endtask

  // Starts on the strobe cycle, samples one full period, ends on the next strobe cycle.
  task automatic run_period(input int chg_at, input logic signed [8:0] chg_val,
                            output int high, output int len, output int strbs);
    high = 0; len = 0; strbs = 0;
    do begin
      if (pwm)  high++;
      if (strb) strbs++;
      if (len == chg_at) pid = chg_val;
      len++;
      @(negedge clk);
    end while (!strb && len < 1000);
    if (len >= 1000)
      chk("period_timeout", len, 510);
  endtask

  int h, l, s, cyc;
  int exp_duty [5] = '{108, 112, 116, 118, 118};
  int exp_high [5] = '{208, 216, 224, 232, 236};

  initial begin
    rstn = 1'b0; enable = 1'b1; pid = 9'sd100;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_duty", duty, 0);
    chk("rst_state", state, 0);
    chk("rst_strb", strb, 0);
    rstn = 1'b1;

    // start-up and kick
    wait_strb(cyc);
    chk("first_strb", cyc, 510);
    chk("kick_state", state, 1);
    chk("kick_duty", duty, 255);
    run_period(-1, 0, h, l, s);
    chk("kick1_high", h, 510);
    chk("kick1_len", l, 510);
    chk("kick1_strbs", s, 1);
    chk("kick2_state", state, 1);
    run_period(-1, 0, h, l, s);
    chk("kick2_high", h, 510);
    chk("run_state", state, 2);
    chk("run_duty", duty, 100);
    run_period(-1, 0, h, l, s);
    chk("run100_high", h, 200);
    chk("run100_hold", duty, 100);

    // slew up
    pid = 9'sd118;
    run_period(-1, 0, h, l, s);
    chk("slew_104", duty, 104);
    for (int i = 0; i < 5; i++) begin
      run_period(-1, 0, h, l, s);
      chk($sformatf("slew_duty_%0d", i), duty, exp_duty[i]);
      chk($sformatf("slew_high_%0d", i), h, exp_high[i]);
    end

    // mid-period demand change must not affect the current period
    run_period(100, 9'sd10, h, l, s);
    chk("midchg_high", h, 236);
    chk("midchg_len", l, 510);
    chk("midchg_strbs", s, 1);
    chk("slew_dn_114", duty, 114);
    for (int i = 0; i < 21; i++)
      run_period(-1, 0, h, l, s);
    chk("min_duty", duty, 32);
    chk("min_state", state, 2);
    run_period(-1, 0, h, l, s);
    chk("min_high", h, 64);
    chk("min_hold", duty, 32);

    // negative demand turns the fan off
    pid = -9'sd9;
    run_period(-1, 0, h, l, s);
    chk("neg_state", state, 0);
    chk("neg_duty", duty, 0);
    run_period(-1, 0, h, l, s);
    chk("off_high", h, 0);

    // kick abort
    pid = 9'sd50;
    run_period(-1, 0, h, l, s);
    chk("abort_kick_state", state, 1);
    enable = 1'b0;
    run_period(-1, 0, h, l, s);
    chk("abort_kick_high", h, 510);
    chk("abort_state", state, 0);
    chk("abort_duty", duty, 0);
    run_period(-1, 0, h, l, s);
    chk("disabled_high", h, 0);
    chk("disabled_state", state, 0);

    // asynchronous reset while pwm is high
    enable = 1'b1;
    run_period(-1, 0, h, l, s);
    chk("rekick_state", state, 1);
    repeat (100) @(negedge clk);
    chk("pre_rst_pwm", pwm, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_pwm", pwm, 0);
    chk("async_duty", duty, 0);
    chk("async_state", state, 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_strb(cyc);
    chk("post_rst_strb", cyc, 510);
    chk("post_rst_state", state, 1);
    chk("post_rst_duty", duty, 255);
    run_period(-1, 0, h, l, s);
    chk("post_rst_len", l, 510);
    chk("post_rst_strbs", s, 1);
    chk("post_rst_kick2", state, 1);
    run_period(-1, 0, h, l, s);
    chk("post_rst_run", state, 2);
    chk("post_rst_run_duty", duty, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
